core_mul_issue: RTL and testbench

- Requester-side controller for the integer multiplier stream interface. Sits between the execute stage and the multiplier.
- Takes one M-extension multiply request (operands, op, destination register) and drives the multiplier's a/b/op streams. It then accepts the r stream and presents a one-cycle writeback.
- Handles pipeline flush mid-operation, a watchdog timeout and an issued-multiply counter.

---
 rtl/core_mul_issue.sv | 136 +++++++++++++
 tb/tb_core_mul_issue.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mul_issue.sv
// Requester-side controller for the integer multiplier streams.
// Issues a/b/op, collects r, and produces a one-cycle writeback.
module core_mul_issue #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ex_req_valid,
  output logic             ex_req_ready,
  input  logic [1:0]       ex_op,
  input  logic [31:0]      ex_rs1_data,
  input  logic [31:0]      ex_rs2_data,
  input  logic [4:0]       ex_rd,
  input  logic             flush,
  output logic [31:0]      int_mul_a_tdata,
  output logic             int_mul_a_tvalid,
  input  logic             int_mul_a_tready,
  output logic [31:0]      int_mul_b_tdata,
  output logic             int_mul_b_tvalid,
  input  logic             int_mul_b_tready,
  output logic [1:0]       int_mul_op_tdata,
  output logic             int_mul_op_tvalid,
  input  logic             int_mul_op_tready,
  input  logic [31:0]      int_mul_r_tdata,
  input  logic             int_mul_r_tvalid,
  output logic             int_mul_r_tready,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [31:0]      wb_data,
  output logic             busy,
  output logic             err_timeout,
  output logic [CNT_W-1:0] mul_count
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    WB
  } state_t;

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t          state;
  state_t          state_d;
  logic [WD_W-1:0] wdog;
  logic            drop;
  logic            accept;
  logic            a_left;
  logic            b_left;
  logic            op_left;
  logic            issue_done;
  logic            r_hs;
  logic            drop_now;
  logic            running;

  assign ex_req_ready = (state == IDLE) && !flush;
  assign accept       = ex_req_valid && ex_req_ready;
  assign busy         = (state != IDLE);
  assign running      = (state == ISSUE) || (state == WAIT);

  // a channel is still pending if valid and not taken this cycle
  assign a_left     = int_mul_a_tvalid && !int_mul_a_tready;
  assign b_left     = int_mul_b_tvalid && !int_mul_b_tready;
  assign op_left    = int_mul_op_tvalid && !int_mul_op_tready;
  assign issue_done = !a_left && !b_left && !op_left;

  assign r_hs     = int_mul_r_tvalid && int_mul_r_tready;
  assign drop_now = drop || flush;
  assign wb_valid = (state == WB) && !flush;

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   if (issue_done) state_d = WAIT;
      WAIT:    if (r_hs) state_d = drop_now ? IDLE : WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      int_mul_a_tdata   <= '0;
      int_mul_b_tdata   <= '0;
      int_mul_op_tdata  <= '0;
      int_mul_a_tvalid  <= 1'b0;
      int_mul_b_tvalid  <= 1'b0;
      int_mul_op_tvalid <= 1'b0;
      int_mul_r_tready  <= 1'b0;
      wb_rd             <= '0;
      wb_data           <= '0;
      drop              <= 1'b0;
      wdog              <= '0;
      err_timeout       <= 1'b0;
      mul_count         <= '0;
    end else begin
      if (accept) begin
        int_mul_a_tdata   <= ex_rs1_data;
        int_mul_b_tdata   <= ex_rs2_data;
        int_mul_op_tdata  <= ex_op;
        wb_rd             <= ex_rd;
        int_mul_a_tvalid  <= 1'b1;
        int_mul_b_tvalid  <= 1'b1;
        int_mul_op_tvalid <= 1'b1;
        drop              <= 1'b0;
        wdog              <= '0;
      end
      if (state == ISSUE) begin
        int_mul_a_tvalid  <= a_left;
        int_mul_b_tvalid  <= b_left;
        int_mul_op_tvalid <= op_left;
        if (issue_done) int_mul_r_tready <= 1'b1;
      end
      if (running && flush) drop <= 1'b1;
      if (r_hs) begin
        wb_data          <= int_mul_r_tdata;
        int_mul_r_tready <= 1'b0;
      end
      if (wb_valid) mul_count <= mul_count + 1'b1;
      // counter saturates; flag rises as it reaches the limit
      if (running && wdog != WD_W'(TIMEOUT_CYCLES)) begin
        wdog <= wdog + 1'b1;
        if (wdog == WD_W'(TIMEOUT_CYCLES - 1)) err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_core_mul_issue.sv
// Directed bench for core_mul_issue: bench acts as the multiplier,
// a scoreboard queue holds expected writebacks for the monitor.
module tb_core_mul_issue;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        ex_req_valid = 1'b0;
  logic        ex_req_ready;
  logic [1:0]  ex_op = '0;
  logic [31:0] ex_rs1_data = '0;
  logic [31:0] ex_rs2_data = '0;
  logic [4:0]  ex_rd = '0;
  logic        flush = 1'b0;
  logic [31:0] int_mul_a_tdata;
  logic        int_mul_a_tvalid;
  logic        int_mul_a_tready = 1'b0;
  logic [31:0] int_mul_b_tdata;
  logic        int_mul_b_tvalid;
  logic        int_mul_b_tready = 1'b0;
  logic [1:0]  int_mul_op_tdata;
  logic        int_mul_op_tvalid;
  logic        int_mul_op_tready = 1'b0;
  logic [31:0] int_mul_r_tdata = '0;
  logic        int_mul_r_tvalid = 1'b0;
  logic        int_mul_r_tready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy;
  logic        err_timeout;
  logic [31:0] mul_count;

  core_mul_issue #(.TIMEOUT_CYCLES(64), .CNT_W(32)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .ex_req_valid(ex_req_valid), .ex_req_ready(ex_req_ready),
    .ex_op(ex_op), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd), .flush(flush),
    .int_mul_a_tdata(int_mul_a_tdata),
    .int_mul_a_tvalid(int_mul_a_tvalid),
    .int_mul_a_tready(int_mul_a_tready),
    .int_mul_b_tdata(int_mul_b_tdata),
    .int_mul_b_tvalid(int_mul_b_tvalid),
    .int_mul_b_tready(int_mul_b_tready),
    .int_mul_op_tdata(int_mul_op_tdata),
    .int_mul_op_tvalid(int_mul_op_tvalid),
    .int_mul_op_tready(int_mul_op_tready),
    .int_mul_r_tdata(int_mul_r_tdata),
    .int_mul_r_tvalid(int_mul_r_tvalid),
    .int_mul_r_tready(int_mul_r_tready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy(busy), .err_timeout(err_timeout), .mul_count(mul_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int          cmp_n = 0;
  int          fail_n = 0;
  int          t = 0;
  int          exp_cnt = 0;
  bit          exp_err = 1'b0;
  logic [1:0]  cur_op;
  logic [31:0] cur_a;
  logic [31:0] cur_b;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    cmp_n++;
    if (act !== exp) begin
      fail_n++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d)", name, act, exp, t);
    end
  endtask

  function automatic logic [31:0] mul_model(logic [1:0] op, logic [31:0] a,
                                            logic [31:0] b);
    logic [65:0] sa;
    logic [65:0] sb;
    logic [65:0] p;
    sa = (op == 2'b01 || op == 2'b10) ? {{34{a[31]}}, a} : {34'b0, a};
    sb = (op == 2'b01) ? {{34{b[31]}}, b} : {34'b0, b};
    p  = sa * sb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
    t++;
  endtask

  task automatic chk_err();
    check("err_timeout", err_timeout, exp_err || (t >= 64));
  endtask

  // writeback monitor
  always @(negedge CLK) begin
    exp_t e;
    if (RST_N && wb_valid) begin
      if (sb_q.size() == 0) begin
        cmp_n++;
        fail_n++;
        $display("FAIL wb_unexpected: got rd=%0d data=0x%0h expected none",
                 wb_rd, wb_data);
      end else begin
        e = sb_q.pop_front();
        check("wb_rd", wb_rd, e.rd);
        check("wb_data", wb_data, e.data);
      end
    end
  end

  task automatic issue_req(logic [1:0] op, logic [31:0] a, logic [31:0] b,
                           logic [4:0] rd);
    cur_op = op;
    cur_a = a;
    cur_b = b;
    ex_req_valid = 1'b1;
    ex_op = op;
    ex_rs1_data = a;
    ex_rs2_data = b;
    ex_rd = rd;
    @(negedge CLK);
    check("ex_req_ready", ex_req_ready, 1);
    check("busy_idle", busy, 0);
    step();
    ex_req_valid = 1'b0;
    ex_rs1_data = 32'hA5A5_A5A5;
    ex_rs2_data = 32'h5A5A_5A5A;
    t = 0;
  endtask

  task automatic issue_phase(int da, int db, int dop, bit early_r);
    int mx;
    mx = (da > db) ? da : db;
    mx = (dop > mx) ? dop : mx;
    for (int k = 0; k <= mx; k++) begin
      int_mul_a_tready = (k == da);
      int_mul_b_tready = (k == db);
      int_mul_op_tready = (k == dop);
      int_mul_r_tvalid = early_r;
      int_mul_r_tdata = 32'hDEAD_BEEF;
      @(negedge CLK);
      check("a_tvalid", int_mul_a_tvalid, k <= da);
      check("b_tvalid", int_mul_b_tvalid, k <= db);
      check("op_tvalid", int_mul_op_tvalid, k <= dop);
      check("a_tdata", int_mul_a_tdata, cur_a);
      check("b_tdata", int_mul_b_tdata, cur_b);
      check("op_tdata", int_mul_op_tdata, cur_op);
      check("r_tready_issue", int_mul_r_tready, 0);
      check("busy_issue", busy, 1);
      chk_err();
      step();
    end
    int_mul_a_tready = 1'b0;
    int_mul_b_tready = 1'b0;
    int_mul_op_tready = 1'b0;
    int_mul_r_tvalid = 1'b0;
  endtask

  // mode: 0 normal, 1 flush in WAIT, 2 flush in WB
  task automatic result_phase(int dr, int mode, logic [4:0] rd,
                              logic [31:0] exp_data);
    if (mode == 1) flush = 1'b1;
    @(negedge CLK);
    check("r_tready_wait", int_mul_r_tready, 1);
    check("tvalid_wait", {int_mul_a_tvalid, int_mul_b_tvalid,
          int_mul_op_tvalid}, 0);
    chk_err();
    step();
    flush = 1'b0;
    for (int k = 0; k < dr; k++) begin
      @(negedge CLK);
      check("r_tready_hold", int_mul_r_tready, 1);
      chk_err();
      step();
    end
    check("a_tdata_at_r", int_mul_a_tdata, cur_a);
    int_mul_r_tvalid = 1'b1;
    int_mul_r_tdata = mul_model(int_mul_op_tdata, int_mul_a_tdata,
                                int_mul_b_tdata);
    if (mode == 0) sb_q.push_back('{rd, exp_data});
    @(negedge CLK);
    check("r_tready_hs", int_mul_r_tready, 1);
    step();
    int_mul_r_tvalid = 1'b0;
    int_mul_r_tdata = '0;
    if (t >= 64) exp_err = 1'b1;
    if (mode == 2) flush = 1'b1;
    @(negedge CLK);
    check("wb_valid_slot", wb_valid, mode == 0);
    check("r_tready_after", int_mul_r_tready, 0);
    check("err_after", err_timeout, exp_err);
    if (mode == 1) check("ex_req_ready_drop", ex_req_ready, 1);
    if (mode == 0) exp_cnt++;
    step();
    flush = 1'b0;
    @(negedge CLK);
    check("mul_count", mul_count, exp_cnt);
    check("busy_done", busy, 0);
    check("wb_valid_once", wb_valid, 0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_valids", {int_mul_a_tvalid, int_mul_b_tvalid,
          int_mul_op_tvalid, int_mul_r_tready, wb_valid, busy}, 0);
    check("rst_err", err_timeout, 0);
    check("rst_count", mul_count, 0);
    check("rst_tdata", {int_mul_a_tdata, int_mul_b_tdata}, 0);
    check("rst_wb", {int_mul_op_tdata, wb_rd, wb_data}, 0);
    RST_N = 1'b1;
    step();

    // flush in IDLE blocks acceptance
    flush = 1'b1;
    ex_req_valid = 1'b1;
    @(negedge CLK);
    check("ready_flush_idle", ex_req_ready, 0);
    step();
    flush = 1'b0;
    ex_req_valid = 1'b0;
    @(negedge CLK);
    check("busy_after_flush_idle", busy, 0);
    step();

    issue_req(2'b00, 32'd7, 32'd6, 5'd5);
    issue_phase(0, 0, 0, 0);
    result_phase(0, 0, 5'd5, 32'd42);

    issue_req(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd10);
    issue_phase(0, 0, 0, 0);
    result_phase(1, 0, 5'd10, 32'h4000_0000);

    issue_req(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31);
    issue_phase(0, 0, 0, 0);
    result_phase(0, 0, 5'd31, 32'hFFFF_FFFE);

    issue_req(2'b10, 32'hFFFF_FFFF, 32'd2, 5'd0);
    issue_phase(0, 0, 0, 0);
    result_phase(2, 0, 5'd0, 32'hFFFF_FFFF);

    issue_req(2'b00, 32'h0001_0000, 32'h0001_0001, 5'd3);
    issue_phase(1, 3, 4, 1);
    result_phase(0, 0, 5'd3, 32'h0001_0000);

    issue_req(2'b00, 32'h1234, 32'd1, 5'd4);
    issue_phase(0, 0, 0, 0);
    result_phase(2, 1, 5'd4, 32'h1234);

    issue_req(2'b00, 32'd9, 32'd9, 5'd6);
    issue_phase(2, 0, 1, 0);
    result_phase(0, 2, 5'd6, 32'd81);

    issue_req(2'b00, 32'd100, 32'd200, 5'd7);
    issue_phase(0, 0, 0, 0);
    result_phase(70, 0, 5'd7, 32'd20000);

    issue_req(2'b00, 32'd2, 32'd3, 5'd8);
    issue_phase(0, 0, 0, 0);
    result_phase(0, 0, 5'd8, 32'd6);

    // async reset while waiting for a result
    issue_req(2'b00, 32'd5, 32'd5, 5'd9);
    issue_phase(0, 0, 0, 0);
    @(negedge CLK);
    check("r_tready_pre_rst", int_mul_r_tready, 1);
    #2;
    RST_N = 1'b0;
    #1;
    check("arst_valids", {int_mul_a_tvalid, int_mul_b_tvalid,
          int_mul_op_tvalid, int_mul_r_tready, wb_valid, busy}, 0);
    check("arst_err", err_timeout, 0);
    check("arst_count", mul_count, 0);
    check("arst_tdata", {int_mul_a_tdata, int_mul_b_tdata}, 0);
    check("arst_wb", {int_mul_op_tdata, wb_rd, wb_data}, 0);
    exp_err = 1'b0;
    exp_cnt = 0;
    @(negedge CLK);
    RST_N = 1'b1;
    step();

    issue_req(2'b00, 32'd3, 32'd3, 5'd12);
    issue_phase(0, 0, 0, 0);
    result_phase(0, 0, 5'd12, 32'd9);

    check("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

endmodule
